// File: rtl/balance_pkg.sv
// Shared definitions for the balance-board round sequencer.
package balance_pkg;

    localparam int SEC_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READY = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Seconds prescaler for the ready countdown; counts 0..DIV-1 while enabled.
module tick_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == CW'(DIV - 1));

    // Disabled means held at zero, so every countdown starts from a full second.
    always_comb begin
        cnt_d = cnt_q;
        if (!en || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/balance_round_ctrl.sv
// Round sequencer: ready countdown, timer start/freeze control and best-time tracking.
//   state    | meaning
//   IDLE     | waiting for go, timer held cleared
//   READY    | counting down READY_SECS seconds, a fall aborts
//   RUN      | timer running until fall or time-out
//   DONE     | timer frozen on the final value until go
module balance_round_ctrl
    import balance_pkg::*;
#(
    parameter int CLK_DIV    = 100_000_000,
    parameter int READY_SECS = 3,
    parameter int MAX_SEC    = 999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             fall,
    input  logic             clr_best,
    input  logic [SEC_W-1:0] sec,
    output logic             timer_start,
    output logic             timer_endn,
    output logic [1:0]       state,
    output logic [1:0]       ready_cnt,
    output logic [SEC_W-1:0] best_sec,
    output logic             new_record,
    output logic             false_start
);

    state_e           state_q, state_d;
    logic [1:0]       ready_cnt_q, ready_cnt_d;
    logic [SEC_W-1:0] best_q, best_d;
    logic             new_record_q, new_record_d;
    logic             false_start_q, false_start_d;
    logic             done_first_q, done_first_d;
    logic             fall_meta_q, fall_s_q;
    logic             tick;
    logic             record;

    tick_prescaler #(
        .DIV (CLK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q == ST_READY),
        .tick (tick)
    );

    always_comb begin
        state_d       = state_q;
        ready_cnt_d   = ready_cnt_q;
        false_start_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d     = ST_READY;
                    ready_cnt_d = 2'(READY_SECS);
                end
            end
            ST_READY: begin
                if (fall_s_q) begin
                    state_d       = ST_IDLE;
                    false_start_d = 1'b1;
                    ready_cnt_d   = 2'd0;
                end else if (tick) begin
                    if (ready_cnt_q > 2'd1) begin
                        ready_cnt_d = ready_cnt_q - 2'd1;
                    end else begin
                        state_d     = ST_RUN;
                        ready_cnt_d = 2'd0;
                    end
                end
            end
            ST_RUN: begin
                if (fall_s_q || (sec >= SEC_W'(MAX_SEC))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (go) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The final time is judged once, on the first frozen cycle; a record beats a clear.
    always_comb begin
        done_first_d = (state_d == ST_DONE) && (state_q != ST_DONE);
        record       = done_first_q && (sec > best_q);
        new_record_d = record;
        best_d       = best_q;
        if (record) begin
            best_d = sec;
        end else if (clr_best) begin
            best_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fall_meta_q   <= 1'b0;
            fall_s_q      <= 1'b0;
            state_q       <= ST_IDLE;
            ready_cnt_q   <= 2'd0;
            best_q        <= '0;
            new_record_q  <= 1'b0;
            false_start_q <= 1'b0;
            done_first_q  <= 1'b0;
        end else begin
            fall_meta_q   <= fall;
            fall_s_q      <= fall_meta_q;
            state_q       <= state_d;
            ready_cnt_q   <= ready_cnt_d;
            best_q        <= best_d;
            new_record_q  <= new_record_d;
            false_start_q <= false_start_d;
            done_first_q  <= done_first_d;
        end
    end

    assign timer_start = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign timer_endn  = (state_q == ST_DONE);
    assign state       = state_q;
    assign ready_cnt   = ready_cnt_q;
    assign best_sec    = best_q;
    assign new_record  = new_record_q;
    assign false_start = false_start_q;

endmodule

// File: tb/tb_balance_round_ctrl.sv
// Bench for balance_round_ctrl: vector table, directed corner sequences, random run vs model.
module tb_balance_round_ctrl;

    localparam int CLK_DIV    = 4;
    localparam int READY_SECS = 3;
    localparam int MAX_SEC    = 999;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       go = 1'b0, fall = 1'b0, clr_best = 1'b0;
    logic [9:0] sec = 10'd0;
    logic       timer_start, timer_endn, new_record, false_start;
    logic [1:0] state, ready_cnt;
    logic [9:0] best_sec;

    int checks   = 0;
    int failures = 0;

    // behavioural model state: phase, cycles spent in READY, best, pulses
    int m_st, m_el, m_best;
    bit m_nr, m_fs, m_first, fp0, fp1;
    bit model_on = 1'b0;

    typedef struct {
        logic       go, fall, clr;
        logic [9:0] sec;
        logic [1:0] st, rc;
        logic       start, endn;
        logic [9:0] best;
        logic       nr, fs;
    } vec_t;
    vec_t vecs[$];

    balance_round_ctrl #(
        .CLK_DIV    (CLK_DIV),
        .READY_SECS (READY_SECS),
        .MAX_SEC    (MAX_SEC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .go          (go),
        .fall        (fall),
        .clr_best    (clr_best),
        .sec         (sec),
        .timer_start (timer_start),
        .timer_endn  (timer_endn),
        .state       (state),
        .ready_cnt   (ready_cnt),
        .best_sec    (best_sec),
        .new_record  (new_record),
        .false_start (false_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_el = 0; m_best = 0;
        m_nr = 0; m_fs = 0; m_first = 0; fp0 = 0; fp1 = 0;
    endtask

    task automatic cyc(input logic g, input logic f, input logic c, input logic [9:0] s);
        int n_st, n_el, n_best, exp_rc;
        bit n_nr, n_fs, n_first;
        go = g; fall = f; clr_best = c; sec = s;
        n_st = m_st; n_el = m_el; n_best = m_best;
        n_nr = 0; n_fs = 0; n_first = 0;
        case (m_st)
            0: if (g) begin n_st = 1; n_el = 0; end
            1: begin
                if (fp1) begin n_st = 0; n_fs = 1; end
                else if (m_el + 1 == READY_SECS * CLK_DIV) n_st = 2;
                else n_el = m_el + 1;
            end
            2: if (fp1 || int'(s) >= MAX_SEC) begin n_st = 3; n_first = 1; end
            default: begin
                if (m_first && int'(s) > m_best) begin n_best = int'(s); n_nr = 1; end
                if (g) n_st = 0;
            end
        endcase
        if (c && !n_nr) n_best = 0;
        @(posedge clk);
        #1;
        m_st = n_st; m_el = n_el; m_best = n_best;
        m_nr = n_nr; m_fs = n_fs; m_first = n_first;
        fp1 = fp0; fp0 = f;
        if (model_on) begin
            exp_rc = (m_st == 1) ? READY_SECS - m_el / CLK_DIV : 0;
            chk("mdl_state", int'(state), m_st);
            chk("mdl_ready_cnt", int'(ready_cnt), exp_rc);
            chk("mdl_start", int'(timer_start), int'(m_st >= 2));
            chk("mdl_endn", int'(timer_endn), int'(m_st == 3));
            chk("mdl_best", int'(best_sec), m_best);
            chk("mdl_new_record", int'(new_record), int'(m_nr));
            chk("mdl_false_start", int'(false_start), int'(m_fs));
        end
    endtask

    task automatic do_reset(input bit chk_en);
        rst = 1'b1; go = 0; fall = 0; clr_best = 0; sec = 0;
        #1;
        if (chk_en) begin
            chk("rst_state", int'(state), 0);
            chk("rst_start", int'(timer_start), 0);
            chk("rst_endn", int'(timer_endn), 0);
            chk("rst_ready_cnt", int'(ready_cnt), 0);
            chk("rst_best", int'(best_sec), 0);
            chk("rst_pulses", int'({new_record, false_start}), 0);
        end
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic start_round();
        repeat (3) cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("go_ready", int'(state), 1);
        repeat (11) cyc(0, 0, 0, 0);
        chk("pre_run", int'(state), 1);
        cyc(0, 0, 0, 0);
        chk("run_entry", int'(state), 2);
        chk("run_start", int'(timer_start), 1);
    endtask

    task automatic end_by_fall(input logic [9:0] s);
        cyc(0, 1, 0, s);
        cyc(0, 1, 0, s);
        chk("fall_sync_run", int'(state), 2);
        cyc(0, 1, 0, s);
        chk("fall_done", int'(state), 3);
        chk("fall_endn", int'(timer_endn), 1);
        cyc(0, 0, 0, s);
    endtask

    task automatic add_vec(input logic g, input logic f, input logic c, input logic [9:0] s,
                           input logic [1:0] st, input logic [1:0] rc, input logic stt,
                           input logic en, input logic [9:0] b, input logic nr, input logic fs);
        vec_t v;
        v.go = g; v.fall = f; v.clr = c; v.sec = s; v.st = st; v.rc = rc;
        v.start = stt; v.endn = en; v.best = b; v.nr = nr; v.fs = fs;
        vecs.push_back(v);
    endtask

    initial begin
        logic       g, fl, c;
        logic [9:0] s;

        // normal round from reset, fall at sec=37, then go back to IDLE
        add_vec(1, 0, 0, 0, 2'd1, 2'd3, 0, 0, 0, 0, 0);
        for (int i = 1; i < 12; i++)
            add_vec(0, 0, 0, 0, 2'd1, (i < 4) ? 2'd3 : ((i < 8) ? 2'd2 : 2'd1), 0, 0, 0, 0, 0);
        add_vec(0, 0, 0, 0,  2'd2, 2'd0, 1, 0, 0,  0, 0);
        add_vec(0, 1, 0, 37, 2'd2, 2'd0, 1, 0, 0,  0, 0);
        add_vec(0, 1, 0, 37, 2'd2, 2'd0, 1, 0, 0,  0, 0);
        add_vec(0, 1, 0, 37, 2'd3, 2'd0, 1, 1, 0,  0, 0);
        add_vec(0, 1, 0, 37, 2'd3, 2'd0, 1, 1, 37, 1, 0);
        add_vec(0, 0, 0, 37, 2'd3, 2'd0, 1, 1, 37, 0, 0);
        add_vec(1, 0, 0, 37, 2'd0, 2'd0, 0, 0, 37, 0, 0);

        do_reset(1);

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].go, vecs[i].fall, vecs[i].clr, vecs[i].sec);
            chk($sformatf("tbl%0d_state", i), int'(state), int'(vecs[i].st));
            chk($sformatf("tbl%0d_ready_cnt", i), int'(ready_cnt), int'(vecs[i].rc));
            chk($sformatf("tbl%0d_start", i), int'(timer_start), int'(vecs[i].start));
            chk($sformatf("tbl%0d_endn", i), int'(timer_endn), int'(vecs[i].endn));
            chk($sformatf("tbl%0d_best", i), int'(best_sec), int'(vecs[i].best));
            chk($sformatf("tbl%0d_new_record", i), int'(new_record), int'(vecs[i].nr));
            chk($sformatf("tbl%0d_false_start", i), int'(false_start), int'(vecs[i].fs));
        end

        // shorter round: no record
        start_round();
        end_by_fall(10'd20);
        chk("short_best", int'(best_sec), 37);
        chk("short_no_record", int'(new_record), 0);
        cyc(1, 0, 0, 0);
        chk("short_idle", int'(state), 0);

        // equal round: not a record
        start_round();
        end_by_fall(10'd37);
        chk("equal_best", int'(best_sec), 37);
        chk("equal_no_record", int'(new_record), 0);
        cyc(1, 0, 0, 0);

        // false start at ready_cnt=2, fall coinciding with a tick
        repeat (3) cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        repeat (5) cyc(0, 0, 0, 0);
        chk("fs_cnt2", int'(ready_cnt), 2);
        cyc(0, 1, 0, 0);
        chk("fs_start_a", int'(timer_start), 0);
        cyc(0, 1, 0, 0);
        chk("fs_still_ready", int'(state), 1);
        chk("fs_start_b", int'(timer_start), 0);
        cyc(0, 1, 0, 0);
        chk("fs_idle", int'(state), 0);
        chk("fs_pulse", int'(false_start), 1);
        chk("fs_cnt0", int'(ready_cnt), 0);
        chk("fs_start_c", int'(timer_start), 0);
        cyc(0, 0, 0, 0);
        chk("fs_pulse_end", int'(false_start), 0);

        // time-out, then clear, then back to IDLE
        start_round();
        cyc(0, 0, 0, 10'd999);
        chk("to_done", int'(state), 3);
        chk("to_endn", int'(timer_endn), 1);
        cyc(0, 0, 0, 10'd999);
        chk("to_best", int'(best_sec), 999);
        chk("to_record", int'(new_record), 1);
        cyc(0, 0, 1, 10'd999);
        chk("clr_best", int'(best_sec), 0);
        chk("clr_no_record", int'(new_record), 0);
        cyc(1, 0, 0, 0);
        chk("to_idle", int'(state), 0);
        chk("to_idle_start", int'(timer_start), 0);

        // go together with synchronised fall in RUN
        start_round();
        cyc(0, 1, 0, 10'd12);
        cyc(0, 1, 0, 10'd12);
        cyc(1, 1, 0, 10'd12);
        chk("coinc_done", int'(state), 3);
        cyc(0, 0, 0, 10'd12);
        chk("coinc_best", int'(best_sec), 12);
        cyc(1, 0, 0, 0);

        // asynchronous reset mid-RUN
        start_round();
        do_reset(1);

        // random run against the model
        model_on = 1'b1;
        fl = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            g = ($urandom_range(0, 5) == 0);
            c = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 11) == 0) fl = ~fl;
            s = ($urandom_range(0, 19) == 0) ? 10'($urandom_range(990, 1023))
                                             : 10'($urandom_range(0, 300));
            cyc(g, fl, c, s);
            if ($urandom_range(0, 499) == 0) begin
                do_reset(1);
                fl = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
